// File: rtl/uart_tx_mmio_if.sv
// CPU-side bus for the memory-mapped UART transmitter: address, write
// data and write enable from the CPU, plus combinational status readback.
interface uart_tx_mmio_if;
    logic [15:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] rd_data;

    modport master (
        output address,
        output data,
        output wren,
        input  rd_data
    );

    modport slave (
        input  address,
        input  data,
        input  wren,
        output rd_data
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter (8N1). Bytes written to TXDATA are queued
// in a small FIFO and shifted out LSB first. STATUS reports the FIFO and
// transmitter state together with a sticky overflow flag.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus,
    output logic           tx,
    output logic           busy
);
    localparam int          PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W       = PTR_W + 1;
    localparam logic [15:0] ADDR_TXDATA = 16'hFFFE;
    localparam logic [15:0] ADDR_STATUS = 16'hFFFD;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [15:0]      baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift_reg, shift_reg_n;
    logic             tx_n;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             fifo_empty, fifo_full;
    logic             push_req, push_ok, pop, clr_ovf;

    // Only the low byte of a TXDATA write is transmitted.
    logic unused_data_hi;
    assign unused_data_hi = ^bus.data[31:8];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign push_req   = bus.wren && (bus.address == ADDR_TXDATA);
    assign clr_ovf    = bus.wren && (bus.address == ADDR_STATUS);
    // The transmitter takes the head on its first idle cycle.
    assign pop        = (state == IDLE) && !fifo_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign busy       = (state != IDLE) || !fifo_empty;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (push_ok && !reset) begin
            fifo_mem[wr_ptr] <= bus.data[7:0];
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmit state register; tx is registered so the line never glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            tx       <= tx_n;
        end
    end

    // Shift register holds the byte in flight; loaded only on a pop.
    always_ff @(posedge clock) begin
        shift_reg <= shift_reg_n;
    end

    // Next-state logic: each bit lasts CLKS_PER_BIT cycles via a down-counter.
    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        shift_reg_n = shift_reg;
        tx_n        = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_reg_n = fifo_mem[rd_ptr];
                    baud_cnt_n  = BAUD_RELOAD;
                    state_n     = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = BAUD_RELOAD;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_reg_n[bit_idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    // STATUS readback, combinational from the address.
    always_comb begin
        bus.rd_data = '0;
        if (bus.address == ADDR_STATUS) begin
            bus.rd_data = {23'd0, 5'(count), overflow, (state != IDLE),
                           fifo_full, fifo_empty};
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the FIFO and line.
module tb_uart_tx_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    logic tx;
    logic busy;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queued bytes, per-cycle line levels of the frame in flight
    // (empty means the transmitter is idle), and the sticky overflow flag.
    logic [7:0] m_fifo[$];
    logic       m_wave[$];
    logic       m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (m_fifo.size() == 0);
        s[1]   = (m_fifo.size() == DEPTH);
        s[2]   = (m_wave.size() != 0);
        s[3]   = m_ovf;
        s[8:4] = 5'(m_fifo.size());
        return s;
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic [15:0] a,
                              input logic [31:0] d);
        logic       do_pop;
        logic       was_full;
        logic [7:0] b;
        if (r) begin
            m_fifo.delete();
            m_wave.delete();
            m_ovf = 1'b0;
            return;
        end
        do_pop   = (m_wave.size() == 0) && (m_fifo.size() != 0);
        was_full = (m_fifo.size() == DEPTH);
        if (do_pop) begin
            b = m_fifo.pop_front();
            for (int i = 0; i < 10 * CPB; i++) begin
                if (i < CPB)           m_wave.push_back(1'b0);
                else if (i < 9 * CPB)  m_wave.push_back(b[(i - CPB) / CPB]);
                else                   m_wave.push_back(1'b1);
            end
        end else if (m_wave.size() != 0) begin
            void'(m_wave.pop_front());
        end
        if (w && a == 16'hFFFE) begin
            if (!was_full || do_pop) m_fifo.push_back(d[7:0]);
            else                     m_ovf = 1'b1;
        end
        if (w && a == 16'hFFFD) m_ovf = 1'b0;
    endtask

    task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                         input logic [31:0] d);
        logic exp_tx;
        @(negedge clock);
        reset       = r;
        bus.wren    = w;
        bus.address = a;
        bus.data    = d;
        @(posedge clock);
        model_edge(r, w, a, d);
        #1;
        exp_tx = (m_wave.size() != 0) ? m_wave[0] : 1'b1;
        check("tx", 32'(tx), 32'(exp_tx));
        check("busy", 32'(busy), 32'((m_wave.size() != 0) || (m_fifo.size() != 0)));
        check("rd_data", bus.rd_data, (a == 16'hFFFD) ? m_status() : 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'hFFFD, 32'h0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [15:0] ra;
        reset       = 1'b1;
        bus.wren    = 1'b0;
        bus.address = 16'h0;
        bus.data    = 32'h0;

        // Reset state
        cycle(1'b1, 1'b0, 16'h0, 32'h0);
        cycle(1'b1, 1'b1, 16'hFFFE, 32'h77);
        cycle(1'b0, 1'b0, 16'hFFFD, 32'h0);
        check("reset_status", bus.rd_data, 32'h00000001);
        check("reset_busy", 32'(busy), 32'h0);

        // Single frame 0xA5
        cycle(1'b0, 1'b1, 16'hFFFE, 32'hDEADBEA5);
        cycle(1'b0, 1'b0, 16'hFFFD, 32'h0);
        check("a5_start_low", 32'(tx), 32'h0);
        idle(39);
        check("a5_busy_in_stop", 32'(busy), 32'h1);
        idle(1);
        check("a5_busy_done", 32'(busy), 32'h0);
        idle(3);

        // Five back-to-back writes fill the FIFO exactly
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 16'hFFFE, 32'(i));
        cycle(1'b0, 1'b0, 16'hFFFD, 32'h0);
        check("five_status", bus.rd_data, 32'h00000046);
        idle(5 * 41 + 5);

        // Six writes overflow; clearing through STATUS
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, 16'hFFFE, 32'(i));
        cycle(1'b0, 1'b0, 16'hFFFD, 32'h0);
        check("ovf_set", 32'(bus.rd_data[3]), 32'h1);
        cycle(1'b0, 1'b1, 16'hFFFD, 32'hFFFFFFFF);
        check("ovf_clear", 32'(bus.rd_data[3]), 32'h0);
        idle(5 * 41 + 5);

        // Ignored addresses
        cycle(1'b0, 1'b1, 16'hFFFF, 32'h55);
        cycle(1'b0, 1'b1, 16'hFFFC, 32'h55);
        idle(3);
        check("bad_addr_tx", 32'(tx), 32'h1);

        // Two queued with a frame active, then reset during DATA
        cycle(1'b0, 1'b1, 16'hFFFE, 32'h11);
        cycle(1'b0, 1'b1, 16'hFFFE, 32'h22);
        cycle(1'b0, 1'b1, 16'hFFFE, 32'h33);
        cycle(1'b0, 1'b0, 16'hFFFD, 32'h0);
        check("status_0x24", bus.rd_data, 32'h00000024);
        idle(5);
        cycle(1'b1, 1'b0, 16'hFFFD, 32'h0);
        check("midframe_reset_tx", 32'(tx), 32'h1);
        cycle(1'b0, 1'b0, 16'hFFFD, 32'h0);
        check("midframe_reset_status", bus.rd_data, 32'h00000001);
        idle(60);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rnd = $urandom_range(0, 199);
            if (rnd < 30) begin
                cycle(1'b0, 1'b1, 16'hFFFE, $urandom);
            end else if (rnd < 34) begin
                cycle(1'b0, 1'b1, 16'hFFFD, $urandom);
            end else if (rnd < 38) begin
                ra = 16'($urandom);
                cycle(1'b0, 1'b1, ra, $urandom);
            end else if (rnd < 40) begin
                cycle(1'b1, $urandom_range(0, 1) == 1, 16'hFFFE, $urandom);
            end else if (rnd < 60) begin
                ra = 16'($urandom);
                cycle(1'b0, 1'b0, ra, $urandom);
            end else begin
                cycle(1'b0, 1'b0, ($urandom_range(0, 1) == 1) ? 16'hFFFD : 16'hFFFE, 32'h0);
            end
        end
        idle(5 * 41 + 10);
        check("final_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..16.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 address  in  16  CPU bus address.
REQ-006 data  in  32  CPU write data.
REQ-007 wren  in  1  CPU write enable.
REQ-008 rd_data  out  32  status readback, combinational from address.
REQ-009 tx  out  1  serial output, idle high.
REQ-010 busy  out  1  high while a frame is in flight or the FIFO is non-empty.

Function
REQ-011 Register map:
- 16'hFFFE: TXDATA, write-only.
- 16'hFFFD: STATUS, read/write.
- All other addresses ignored by this block.
REQ-012 Write with wren=1 and address=16'hFFFE pushes data[7:0] into the FIFO; data[31:8] ignored.
REQ-013 Write with wren=1 and address=16'hFFFD clears the sticky overflow flag; data ignored.
REQ-014 rd_data when address=16'hFFFD:
- bit0 = empty
- bit1 = full
- bit2 = tx state != IDLE
- bit3 = overflow
- bits[8:4] = FIFO count (0..FIFO_DEPTH)
- all other bits 0
REQ-015 rd_data = 32'h0 for any other address.
REQ-016 Push while full with no pop in the same cycle: byte dropped, count unchanged, overflow set.
REQ-017 Push while full with a pop in the same cycle: push accepted, count stays FIFO_DEPTH, overflow not set.
REQ-018 Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged, FIFO order preserved.
REQ-019 FIFO pointers wrap modulo FIFO_DEPTH; count is held separately so full and empty are unambiguous.
REQ-020 Transmit state machine states: IDLE, START, DATA, STOP.
REQ-021 IDLE:
- tx=1.
- If FIFO non-empty: pop head into shift register, load baud counter with CLKS_PER_BIT-1, go to START.
REQ-022 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-023 DATA:
- tx = shift register bit[index], LSB first, each bit held CLKS_PER_BIT cycles.
- After bit 7 completes, go to STOP.
REQ-024 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-025 A queued byte is popped on the first IDLE cycle, so back-to-back frames have exactly one idle-high cycle between stop bit and next start bit.
REQ-026 Latency:
- Write accepted at edge k into an empty FIFO with FSM in IDLE.
- FSM enters START and tx falls after edge k+1.
REQ-027 Frame length: 10*CLKS_PER_BIT cycles from tx falling to the end of the stop bit.
REQ-028 Baud counter counts down, reloads with CLKS_PER_BIT-1 at every bit boundary, width 16 bits.
REQ-029 busy = (state != IDLE) | !empty, combinational.

Reset
REQ-030 While reset=1 at a rising edge, the block enters its reset state:
- state=IDLE, tx=1
- FIFO pointers=0, count=0, overflow=0
- baud counter=0, bit index=0
REQ-031 Writes presented in the same cycle as reset are discarded.
REQ-032 Reset mid-frame aborts the frame: tx=1 from the following cycle and all queued bytes are lost.
REQ-033 After reset release, busy=0 and STATUS reads 32'h00000001.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Write 32'h000000A5 to 16'hFFFE -> tx low one cycle later; bits 1,0,1,0,0,1,0,1, 4 cycles each; stop bit high; busy falls after 40 cycles of frame.
REQ-035 Five writes 8'h01..8'h05 on consecutive cycles -> first pops immediately, remaining four fill FIFO, all five transmitted in order; overflow stays 0.
REQ-036 Six writes on consecutive cycles -> 8'h06 dropped, STATUS bit3=1; write to 16'hFFFD -> bit3=0.
REQ-037 Assert reset during the DATA state of a frame -> tx=1 next cycle, STATUS=32'h00000001, no further frames sent.
REQ-038 Write to 16'hFFFF or 16'hFFFC with wren=1 -> no FIFO change, tx stays high.
REQ-039 Read 16'hFFFD with 2 bytes queued and a frame active -> rd_data=32'h00000024.
